// File: rtl/bus_gearbox_if.sv
// Handshaked narrow-in / wide-out bus bundle for bus_gearbox.
// The gearbox connects through the slave modport; the producer/consumer side uses master.
interface bus_gearbox_if #(
   parameter int IN_W  = 5,
   parameter int OUT_W = 8
);
   logic [IN_W-1:0]          in_data;
   logic                     in_valid;
   logic                     in_last;
   logic                     in_ready;
   logic [OUT_W-1:0]         out_data;
   logic                     out_valid;
   logic                     out_last;
   logic [$clog2(OUT_W)-1:0] out_pad;
   logic                     out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_pad
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, out_pad
   );
endinterface

// File: rtl/bus_gearbox.sv
// Packs a stream of IN_W-bit chunks into OUT_W-bit words, LSB first, and
// flushes a zero-padded partial word at the end of each packet.
module bus_gearbox #(
   parameter int IN_W  = 5,
   parameter int OUT_W = 8
) (
   input logic         clk,
   input logic         rst_n,
   bus_gearbox_if.slave bus
);
   localparam int ACC_W = OUT_W + IN_W - 1;
   localparam int CNT_W = $clog2(OUT_W + IN_W);
   localparam int PAD_W = $clog2(OUT_W);
   localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);
   localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_W);

   if (IN_W < 1 || IN_W >= OUT_W) begin : g_bad_params
      $error("bus_gearbox: IN_W must satisfy 1 <= IN_W < OUT_W");
   end

   typedef enum logic {FILL, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               full;
   logic               in_xfer;
   logic               out_xfer;
   logic [OUT_W-1:0]   out_word;

   // All handshake outputs are decoded from registers only.
   assign full          = (cnt_q >= OUT_C);
   assign bus.in_ready  = (state_q == FILL) && !full;
   assign bus.out_valid = full || ((state_q == DRAIN) && (cnt_q != '0));
   assign bus.out_last  = (state_q == DRAIN) && (cnt_q <= OUT_C);
   assign bus.out_pad   = bus.out_last ? PAD_W'(OUT_C - cnt_q) : '0;
   assign bus.out_data  = out_word;

   assign in_xfer  = bus.in_valid && bus.in_ready;
   assign out_xfer = bus.out_valid && bus.out_ready;

   always_comb begin
      out_word = acc_q[OUT_W-1:0];
      if (!full) begin
         for (int i = 0; i < OUT_W; i++) begin
            if (CNT_W'(i) >= cnt_q) out_word[i] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      if (in_xfer) begin
         acc_d[cnt_q +: IN_W] = bus.in_data;
         cnt_d                = cnt_q + IN_C;
         if (bus.in_last) state_d = DRAIN;
      end else if (out_xfer) begin
         if (full) begin
            acc_d = acc_q >> OUT_W;
            cnt_d = cnt_q - OUT_C;
         end else begin
            acc_d = '0;
            cnt_d = '0;
         end
         if (bus.out_last) state_d = FILL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   a_no_dual_xfer: assert property (@(posedge clk) disable iff (!rst_n) !(in_xfer && out_xfer));
endmodule

// File: tb/tb_bus_gearbox.sv
// Directed bench for bus_gearbox plus a randomized handshake run checked
// against a bit-stream packing model.
module tb_bus_gearbox;
   localparam int IN_W  = 5;
   localparam int OUT_W = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bus_gearbox_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   bus_gearbox #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [11:0] rxq[$];
   logic [11:0] expq[$];
   bit          pkt[$];
   logic        rnd_mode  = 1'b0;
   logic        rnd_ready = 1'b0;
   logic        dir_ready = 1'b0;
   logic [4:0]  rd;
   logic        rl;
   int          idle;
   int          w;

   assign bus.out_ready = rnd_mode ? rnd_ready : dir_ready;

   // Record every accepted output word as {data, last, pad}.
   always @(posedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready)
         rxq.push_back({bus.out_data, bus.out_last, bus.out_pad});
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rnd_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] d, input logic l);
      int t = 0;
      bus.in_data  = d;
      bus.in_last  = l;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && t < 100) begin
         step();
         t++;
      end
      chk("push_ready_timeout", 32'(t < 100), 32'd1);
      step();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_rx(input int n, input string tag);
      int t = 0;
      while (rxq.size() < n && t < 300) begin
         step();
         t++;
      end
      chk(tag, 32'(rxq.size()), 32'(n));
   endtask

   task automatic chk_word(input int idx, input logic [7:0] d, input logic l,
                           input logic [2:0] p, input string tag);
      logic [11:0] got;
      got = (idx < rxq.size()) ? rxq[idx] : 12'hxxx;
      chk(tag, 32'(got), 32'({d, l, p}));
   endtask

   task automatic emit(input logic last_w);
      logic [11:0] word;
      int          n;
      word = '0;
      n    = (pkt.size() < OUT_W) ? pkt.size() : OUT_W;
      for (int i = 0; i < n; i++) word[4+i] = pkt.pop_front();
      word[3]   = last_w;
      word[2:0] = last_w ? 3'(OUT_W - n) : 3'd0;
      expq.push_back(word);
   endtask

   initial begin
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      rst_n        = 1'b0;
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_out_last",  32'(bus.out_last),  32'd0);
      chk("rst_out_pad",   32'(bus.out_pad),   32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // Continuous stream without packet end.
      rxq.delete();
      dir_ready = 1'b1;
      push(5'h03, 1'b0);
      push(5'h1C, 1'b0);
      repeat (6) push(5'h1F, 1'b0);
      wait_rx(5, "stream_count");
      chk_word(0, 8'h83, 1'b0, 3'd0, "stream_w0");
      for (int i = 1; i < 5; i++) chk_word(i, 8'hFF, 1'b0, 3'd0, "stream_ones");
      chk("stream_idle_valid", 32'(bus.out_valid), 32'd0);

      // Two-chunk packet flushed with padding.
      rxq.delete();
      push(5'h03, 1'b0);
      push(5'h1C, 1'b1);
      wait_rx(2, "pkt2_count");
      chk_word(0, 8'h83, 1'b0, 3'd0, "pkt2_w0");
      chk_word(1, 8'h03, 1'b1, 3'd6, "pkt2_w1_last");
      chk("pkt2_in_ready", 32'(bus.in_ready), 32'd1);
      chk("pkt2_out_valid", 32'(bus.out_valid), 32'd0);

      // Single-chunk packet.
      rxq.delete();
      push(5'h1A, 1'b1);
      wait_rx(1, "single_count");
      chk_word(0, 8'h1A, 1'b1, 3'd3, "single_w0");

      // Reach cnt=3, then a chunk completes a word that is held by backpressure.
      rxq.delete();
      repeat (7) push(5'h1F, 1'b0);
      w = 0;
      while (bus.out_valid && w < 50) begin
         step();
         w++;
      end
      chk("hold_drain_timeout", 32'(w < 50), 32'd1);
      dir_ready = 1'b0;
      chk("hold_pre_count", 32'(rxq.size()), 32'd4);
      push(5'h0A, 1'b0);
      chk("hold_latency_valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid",    32'(bus.out_valid), 32'd1);
         chk("hold_data",     32'(bus.out_data),  32'h57);
         chk("hold_in_ready", 32'(bus.in_ready),  32'd0);
         step();
      end
      chk("hold_no_pop", 32'(rxq.size()), 32'd4);
      dir_ready = 1'b1;
      wait_rx(5, "hold_count");
      chk_word(4, 8'h57, 1'b0, 3'd0, "hold_word");

      // Reset while draining the tail of a packet.
      rxq.delete();
      dir_ready = 1'b0;
      push(5'h03, 1'b0);
      push(5'h1C, 1'b1);
      chk("drain_w0_data", 32'(bus.out_data), 32'h83);
      dir_ready = 1'b1;
      step();
      dir_ready = 1'b0;
      chk("drain_tail_data", 32'(bus.out_data),  32'h03);
      chk("drain_tail_last", 32'(bus.out_last),  32'd1);
      chk("drain_tail_pad",  32'(bus.out_pad),   32'd6);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_out_last",  32'(bus.out_last),  32'd0);
      chk("midrst_out_data",  32'(bus.out_data),  32'd0);
      chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
      step();
      rst_n = 1'b1;
      rxq.delete();
      dir_ready = 1'b1;
      push(5'h05, 1'b1);
      wait_rx(1, "postrst_count");
      chk_word(0, 8'h05, 1'b1, 3'd3, "postrst_word");

      // Random handshakes checked against a bit-stream packing model.
      rxq.delete();
      expq.delete();
      pkt.delete();
      rnd_mode = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         rd   = 5'($urandom);
         rl   = (k == 1999) || ($urandom_range(0, 7) == 0);
         idle = $urandom_range(0, 2);
         repeat (idle) step();
         push(rd, rl);
         for (int b = 0; b < IN_W; b++) pkt.push_back(rd[b]);
         if (!rl) begin
            while (pkt.size() >= OUT_W) emit(1'b0);
         end else begin
            while (pkt.size() > OUT_W) emit(1'b0);
            emit(1'b1);
         end
      end
      wait_rx(expq.size(), "rand_count");
      for (int i = 0; i < expq.size(); i++) begin
         chk("rand_word", 32'((i < rxq.size()) ? rxq[i] : 12'hxxx), 32'(expq[i]));
      end
      rnd_mode = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
